rcu_pll_seq: RTL and testbench

- PLL switch sequencer that sits directly upstream of the reset/clock unit and drives its PLL configuration and core-clock mux enable (pll_en).
- Runs on the bypass reference clock (low-frequency oscillator) and accepts a frequency-change request.
- Moves the core clock to bypass, reprograms the PLL, waits for a qualified lock with a timeout, then switches back to the PLL clock.
- Monitors lock while on the PLL and falls back to bypass on loss of lock.

---
 rtl/rcu_pll_seq_if.sv | 26 ++
 rtl/rcu_pll_seq.sv | 187 ++++++++++++++++++
 tb/tb_rcu_pll_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rcu_pll_seq_if.sv
// Request handshake, PLL lock input and clock-control outputs of the PLL switch sequencer.
interface rcu_pll_seq_if #(
   parameter int CFG_WIDTH     = 3,
   parameter int TIMEOUT_WIDTH = 16
);
   logic                     req_valid_i;
   logic                     req_ready_o;
   logic [CFG_WIDTH-1:0]     req_cfg_i;
   logic [TIMEOUT_WIDTH-1:0] timeout_i;
   logic                     pll_lock_i;
   logic [CFG_WIDTH-1:0]     clk_cfg_o;
   logic                     pll_en_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_o;

   modport slave (
      input  req_valid_i, req_cfg_i, timeout_i, pll_lock_i,
      output req_ready_o, clk_cfg_o, pll_en_o, busy_o, done_o, err_o
   );

   modport master (
      output req_valid_i, req_cfg_i, timeout_i, pll_lock_i,
      input  req_ready_o, clk_cfg_o, pll_en_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/rcu_pll_seq.sv
// PLL switch sequencer: parks the core clock on bypass, reprograms the PLL, qualifies lock
// with a timeout, switches back to the PLL and falls back to bypass on loss of lock.
module rcu_pll_seq #(
   parameter int CFG_WIDTH     = 3,
   parameter int TIMEOUT_WIDTH = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_CYCLES = 16
) (
   input logic          clk_i,
   input logic          rst_n_i,
   rcu_pll_seq_if.slave bus
);
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int STB_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SET_W-1:0]         SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [STB_W-1:0]         STABLE_MAX  = STB_W'(STABLE_CYCLES);
   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX   = {TIMEOUT_WIDTH{1'b1}};
   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ZERO  = {TIMEOUT_WIDTH{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_BYPASS    = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_SWITCH    = 3'd4
   } state_t;

   state_t                   state_r, state_nxt_s;
   logic                     sync_meta_r, sync_lock_r, lock_s;
   logic [CFG_WIDTH-1:0]     cfg_req_r, cfg_req_nxt_s;
   logic [TIMEOUT_WIDTH-1:0] timeout_r, timeout_nxt_s;
   logic [SET_W-1:0]         settle_cnt_r, settle_cnt_nxt_s;
   logic [TIMEOUT_WIDTH-1:0] timer_r, timer_nxt_s, timer_inc_s;
   logic [STB_W-1:0]         stable_cnt_r, stable_cnt_nxt_s, stable_inc_s;
   logic [CFG_WIDTH-1:0]     clk_cfg_r, clk_cfg_nxt_s;
   logic                     pll_en_r, pll_en_nxt_s;
   logic                     done_r, done_nxt_s;
   logic                     err_r, err_nxt_s;
   logic                     accept_s, noop_s, timeout_hit_s;

   assign lock_s        = sync_lock_r;
   assign accept_s      = bus.req_valid_i && (state_r == ST_IDLE);
   // A request that changes nothing is only a no-op while the PLL is still qualified as locked.
   assign noop_s        = accept_s && (bus.req_cfg_i == clk_cfg_r) && pll_en_r && lock_s;
   assign timer_inc_s   = (timer_r == TIMER_MAX) ? timer_r : (timer_r + TIMEOUT_WIDTH'(1));
   assign timeout_hit_s = (timeout_r != TIMER_ZERO) && (timer_inc_s == timeout_r);
   assign stable_inc_s  = stable_cnt_r + STB_W'(1);

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_meta_r <= 1'b0;
         sync_lock_r <= 1'b0;
      end else begin
         sync_meta_r <= bus.pll_lock_i;
         sync_lock_r <= sync_meta_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a timeout wins over lock qualification.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && !noop_s) state_nxt_s = ST_BYPASS;
            else                     state_nxt_s = ST_IDLE;
         end
         ST_BYPASS: begin
            if (settle_cnt_r == SETTLE_LAST) state_nxt_s = ST_WAIT_LOCK;
            else                             state_nxt_s = ST_BYPASS;
         end
         ST_WAIT_LOCK: begin
            if (timeout_hit_s)                               state_nxt_s = ST_IDLE;
            else if (lock_s && (STB_W'(1) == STABLE_MAX))    state_nxt_s = ST_SWITCH;
            else if (lock_s)                                 state_nxt_s = ST_STABLE;
            else                                             state_nxt_s = ST_WAIT_LOCK;
         end
         ST_STABLE: begin
            if (timeout_hit_s)                   state_nxt_s = ST_IDLE;
            else if (!lock_s)                    state_nxt_s = ST_WAIT_LOCK;
            else if (stable_inc_s == STABLE_MAX) state_nxt_s = ST_SWITCH;
            else                                 state_nxt_s = ST_STABLE;
         end
         ST_SWITCH: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output and datapath next values.
   always_comb begin
      cfg_req_nxt_s    = cfg_req_r;
      timeout_nxt_s    = timeout_r;
      settle_cnt_nxt_s = {SET_W{1'b0}};
      timer_nxt_s      = TIMER_ZERO;
      stable_cnt_nxt_s = {STB_W{1'b0}};
      clk_cfg_nxt_s    = clk_cfg_r;
      pll_en_nxt_s     = pll_en_r;
      done_nxt_s       = 1'b0;
      err_nxt_s        = err_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               cfg_req_nxt_s = bus.req_cfg_i;
               timeout_nxt_s = bus.timeout_i;
               if (noop_s) begin
                  done_nxt_s = 1'b1;
               end else begin
                  pll_en_nxt_s = 1'b0;
                  err_nxt_s    = 1'b0;
               end
            end else if (pll_en_r && !lock_s) begin
               pll_en_nxt_s = 1'b0;
               err_nxt_s    = 1'b1;
            end else begin
               pll_en_nxt_s = pll_en_r;
            end
         end
         ST_BYPASS: begin
            settle_cnt_nxt_s = settle_cnt_r + SET_W'(1);
            if (settle_cnt_r == SETTLE_LAST) clk_cfg_nxt_s = cfg_req_r;
            else                             clk_cfg_nxt_s = clk_cfg_r;
         end
         ST_WAIT_LOCK, ST_STABLE: begin
            // The stable counter is always zero in WAIT_LOCK, so the increment also yields 1 there.
            timer_nxt_s = timer_inc_s;
            if (timeout_hit_s) begin
               done_nxt_s = 1'b1;
               err_nxt_s  = 1'b1;
            end else if (state_nxt_s == ST_SWITCH) begin
               pll_en_nxt_s = 1'b1;
               done_nxt_s   = 1'b1;
            end else if (lock_s) begin
               stable_cnt_nxt_s = stable_inc_s;
            end else begin
               stable_cnt_nxt_s = {STB_W{1'b0}};
            end
         end
         ST_SWITCH: begin
            done_nxt_s = 1'b0;
         end
         default: begin
            pll_en_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cfg_req_r    <= {CFG_WIDTH{1'b0}};
         timeout_r    <= TIMER_ZERO;
         settle_cnt_r <= {SET_W{1'b0}};
         timer_r      <= TIMER_ZERO;
         stable_cnt_r <= {STB_W{1'b0}};
         clk_cfg_r    <= {CFG_WIDTH{1'b0}};
         pll_en_r     <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         cfg_req_r    <= cfg_req_nxt_s;
         timeout_r    <= timeout_nxt_s;
         settle_cnt_r <= settle_cnt_nxt_s;
         timer_r      <= timer_nxt_s;
         stable_cnt_r <= stable_cnt_nxt_s;
         clk_cfg_r    <= clk_cfg_nxt_s;
         pll_en_r     <= pll_en_nxt_s;
         done_r       <= done_nxt_s;
         err_r        <= err_nxt_s;
      end
   end

   assign bus.req_ready_o = (state_r == ST_IDLE);
   assign bus.busy_o      = (state_r != ST_IDLE);
   assign bus.clk_cfg_o   = clk_cfg_r;
   assign bus.pll_en_o    = pll_en_r;
   assign bus.done_o      = done_r;
   assign bus.err_o       = err_r;
endmodule

// File: tb/tb_rcu_pll_seq.sv
// Directed bench for rcu_pll_seq: a procedural reference model checked every cycle,
// plus hand-computed latency checks at the key events.
module tb_rcu_pll_seq;
   localparam int CW     = 3;
   localparam int TW     = 16;
   localparam int SETTLE = 4;
   localparam int STABLE = 16;
   localparam int TMAX   = (1 << TW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   rcu_pll_seq_if #(.CFG_WIDTH(CW), .TIMEOUT_WIDTH(TW)) bus ();

   rcu_pll_seq #(
      .CFG_WIDTH(CW), .TIMEOUT_WIDTH(TW), .SETTLE_CYCLES(SETTLE), .STABLE_CYCLES(STABLE)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic          exp_pll_en, exp_done, exp_err, exp_busy, exp_ready;
   logic [CW-1:0] exp_cfg;
   logic          hist0, hist1, lock_now;
   bit            abort;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 100)
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: one call advances one clock edge; lock is seen two edges late.
   task automatic step();
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         abort = 1'b1;
      end else begin
         lock_now = hist1;
         hist1    = hist0;
         hist0    = bus.pll_lock_i;
      end
   endtask

   task automatic model_reset();
      exp_pll_en = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_busy   = 1'b0; exp_ready = 1'b1; exp_cfg = '0;
      hist0 = 1'b0; hist1 = 1'b0; lock_now = 1'b0;
   endtask

   task automatic run_seq(input logic [CW-1:0] cfg, input logic [TW-1:0] to);
      int elapsed;
      int run;
      exp_pll_en = 1'b0; exp_err = 1'b0; exp_busy = 1'b1; exp_ready = 1'b0; exp_done = 1'b0;
      repeat (SETTLE) begin
         step();
         if (abort) return;
      end
      exp_cfg = cfg;
      elapsed = 0;
      run     = 0;
      forever begin
         step();
         if (abort) return;
         if (elapsed < TMAX) elapsed++;
         if (to != '0 && elapsed == int'(to)) begin
            exp_err = 1'b1; exp_done = 1'b1; exp_busy = 1'b0; exp_ready = 1'b1;
            return;
         end
         run = lock_now ? run + 1 : 0;
         if (run == STABLE) begin
            exp_pll_en = 1'b1; exp_done = 1'b1;
            step();
            if (abort) return;
            exp_done = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
            return;
         end
      end
   endtask

   task automatic model_main();
      forever begin
         step();
         if (abort) return;
         exp_done = 1'b0;
         if (bus.req_valid_i) begin
            if (bus.req_cfg_i == exp_cfg && exp_pll_en && lock_now) begin
               exp_done = 1'b1;
            end else begin
               run_seq(bus.req_cfg_i, bus.timeout_i);
               if (abort) return;
            end
         end else if (exp_pll_en && !lock_now) begin
            exp_pll_en = 1'b0;
            exp_err    = 1'b1;
         end
      end
   endtask

   initial begin : model_proc
      forever begin
         abort = 1'b0;
         model_reset();
         wait (rst_n === 1'b1);
         model_main();
      end
   end

   // Cycle-by-cycle comparison against the model on the inactive edge.
   initial begin : compare_proc
      forever begin
         @(negedge clk);
         check("pll_en",    32'(bus.pll_en_o),    32'(exp_pll_en));
         check("clk_cfg",   32'(bus.clk_cfg_o),   32'(exp_cfg));
         check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
         check("busy",      32'(bus.busy_o),      32'(exp_busy));
         check("done",      32'(bus.done_o),      32'(exp_done));
         check("err",       32'(bus.err_o),       32'(exp_err));
      end
   end

   task automatic send(input logic [CW-1:0] cfg, input logic [TW-1:0] to);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_cfg_i   = cfg;
      bus.timeout_i   = to;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
   endtask

   // Counts negedges until the selected output equals val (0 cfg, 1 done, 2 err, 3 pll_en).
   task automatic wait_until(input int sel, input int val, input int limit, output int cnt);
      int hit;
      cnt = 0;
      hit = 0;
      while (cnt < limit && hit == 0) begin
         @(negedge clk);
         cnt++;
         case (sel)
            0:       hit = (int'(bus.clk_cfg_o) == val) ? 1 : 0;
            1:       hit = (int'(bus.done_o)    == val) ? 1 : 0;
            2:       hit = (int'(bus.err_o)     == val) ? 1 : 0;
            default: hit = (int'(bus.pll_en_o)  == val) ? 1 : 0;
         endcase
      end
      if (hit == 0) cnt = -1;
   endtask

   initial begin : stim
      int cnt;
      bus.req_valid_i = 1'b0;
      bus.req_cfg_i   = '0;
      bus.timeout_i   = '0;
      bus.pll_lock_i  = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pll_en", 32'(bus.pll_en_o),    32'd0);
      check("rst_cfg",    32'(bus.clk_cfg_o),   32'd0);
      check("rst_ready",  32'(bus.req_ready_o), 32'd1);
      #2 rst_n = 1'b1;

      // Successful switch to cfg 5.
      send(3'd5, 16'd1000);
      check("t1_busy", 32'(bus.busy_o), 32'd1);
      wait_until(0, 5, 20, cnt);
      check("t1_cfg_lat", 32'(cnt), 32'd4);
      repeat (20) @(negedge clk);
      bus.pll_lock_i = 1'b1;
      wait_until(1, 1, 40, cnt);
      check("t1_lock_to_switch", 32'(cnt), 32'd18);
      check("t1_pll_en", 32'(bus.pll_en_o), 32'd1);
      check("t1_err",    32'(bus.err_o),    32'd0);

      // Loss of lock while running on the PLL.
      bus.pll_lock_i = 1'b0;
      wait_until(2, 1, 10, cnt);
      check("t4_loss_lat", 32'(cnt), 32'd3);
      check("t4_pll_en",   32'(bus.pll_en_o),  32'd0);
      check("t4_cfg",      32'(bus.clk_cfg_o), 32'd5);

      // Timeout with lock never asserting.
      send(3'd2, 16'd50);
      check("t2_err_clr", 32'(bus.err_o), 32'd0);
      wait_until(0, 2, 20, cnt);
      check("t2_cfg_lat", 32'(cnt), 32'd4);
      wait_until(2, 1, 80, cnt);
      check("t2_timeout_lat", 32'(cnt), 32'd50);
      check("t2_done",   32'(bus.done_o),   32'd1);
      check("t2_pll_en", 32'(bus.pll_en_o), 32'd0);
      @(negedge clk);
      check("t2_ready", 32'(bus.req_ready_o), 32'd1);

      // One-cycle lock glitch restarts qualification.
      send(3'd3, 16'd1000);
      wait_until(0, 3, 20, cnt);
      repeat (3) @(negedge clk);
      bus.pll_lock_i = 1'b1;
      repeat (10) @(negedge clk);
      bus.pll_lock_i = 1'b0;
      @(negedge clk);
      bus.pll_lock_i = 1'b1;
      wait_until(1, 1, 40, cnt);
      check("t3_relock_to_switch", 32'(cnt), 32'd18);

      // No-op request keeps the PLL clock.
      send(3'd3, 16'd100);
      check("t5_noop_done",   32'(bus.done_o),   32'd1);
      check("t5_noop_pll_en", 32'(bus.pll_en_o), 32'd1);

      // Unlimited timeout with a very late lock.
      send(3'd6, 16'd0);
      bus.pll_lock_i = 1'b0;
      check("t6_pll_en_fall", 32'(bus.pll_en_o), 32'd0);
      wait_until(0, 6, 20, cnt);
      repeat (70000) @(negedge clk);
      bus.pll_lock_i = 1'b1;
      wait_until(1, 1, 40, cnt);
      check("t6_late_lock", 32'(cnt), 32'd18);
      check("t6_err", 32'(bus.err_o), 32'd0);

      // Reset in the middle of lock qualification.
      send(3'd1, 16'd1000);
      wait_until(0, 1, 20, cnt);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t7_pll_en", 32'(bus.pll_en_o),    32'd0);
      check("t7_cfg",    32'(bus.clk_cfg_o),   32'd0);
      check("t7_busy",   32'(bus.busy_o),      32'd0);
      check("t7_ready",  32'(bus.req_ready_o), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      send(3'd5, 16'd1000);
      wait_until(1, 1, 60, cnt);
      check("t7_recover", 32'(cnt), 32'd20);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
